wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/core_pkg.sv | 12 +
 rtl/wb_arbiter_rr_pick2.sv | 41 ++++
 rtl/wb_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Core-wide types shared by rename, issue and writeback.
// Physical tag and ROB index widths derive from the sizes below.
package core_pkg;

    localparam int XLEN  = 32;
    localparam int PREGS = 64;
    localparam int ROBSZ = 32;

    typedef logic [$clog2(PREGS)-1:0] preg_tag_t;
    typedef logic [$clog2(ROBSZ)-1:0] rob_idx_t;

endpackage

// File: rtl/wb_arbiter_rr_pick2.sv
// Combinational two-winner circular priority picker.
// Scans from ptr_i upward with wrap; first hit -> gnt0, second -> gnt1.
module rr_pick2 #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt0_o,
    output logic [N-1:0]  gnt1_o,
    output logic          found0_o,
    output logic          found1_o
);

    logic [PW-1:0] idx;
    logic          f0;
    logic          f1;

    always_comb begin
        gnt0_o = '0;
        gnt1_o = '0;
        f0     = 1'b0;
        f1     = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (valid_i[idx]) begin
                if (!f0) begin
                    gnt0_o[idx] = 1'b1;
                    f0          = 1'b1;
                end else if (!f1) begin
                    gnt1_o[idx] = 1'b1;
                    f1          = 1'b1;
                end
            end
        end
        found0_o = f0;
        found1_o = f1;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Dual-port writeback arbiter: picks up to two FU results per cycle
// round-robin and registers them onto the PRF write / CDB ports.
module wb_arbiter
    import core_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int XLEN  = core_pkg::XLEN,
    parameter int PREGS = core_pkg::PREGS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  preg_tag_t [NREQ-1:0]       req_tag,
    input  logic [NREQ-1:0][XLEN-1:0]  req_data,
    input  rob_idx_t [NREQ-1:0]        req_rob,
    output logic                       wen0,
    output logic                       wen1,
    output preg_tag_t                  wtag0,
    output preg_tag_t                  wtag1,
    output logic [XLEN-1:0]            wdata0,
    output logic [XLEN-1:0]            wdata1,
    output rob_idx_t                   cdb_rob0,
    output rob_idx_t                   cdb_rob1
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt0, gnt1;
    logic            found0, found1;
    logic [PW-1:0]   idx0, idx1, last;

    preg_tag_t       tag0_d, tag1_d;
    logic [XLEN-1:0] data0_d, data1_d;
    rob_idx_t        rob0_d, rob1_d;

    logic            wen0_q, wen1_q;
    preg_tag_t       wtag0_q, wtag1_q;
    logic [XLEN-1:0] wdata0_q, wdata1_q;
    rob_idx_t        rob0_q, rob1_q;

    rr_pick2 #(.N(NREQ)) u_pick (
        .valid_i  (req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1),
        .found0_o (found0),
        .found1_o (found1)
    );

    // No grants are issued while reset is held.
    assign req_ready = reset ? '0 : (gnt0 | gnt1);

    always_comb begin
        tag0_d  = '0;
        tag1_d  = '0;
        data0_d = '0;
        data1_d = '0;
        rob0_d  = '0;
        rob1_d  = '0;
        idx0    = '0;
        idx1    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt0[i]) begin
                tag0_d  = req_tag[i];
                data0_d = req_data[i];
                rob0_d  = req_rob[i];
                idx0    = PW'(i);
            end
            if (gnt1[i]) begin
                tag1_d  = req_tag[i];
                data1_d = req_data[i];
                rob1_d  = req_rob[i];
                idx1    = PW'(i);
            end
        end
        last     = found1 ? idx1 : idx0;
        rr_ptr_d = rr_ptr_q;
        if (found0) begin
            rr_ptr_d = PW'((int'(last) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            wen0_q   <= 1'b0;
            wen1_q   <= 1'b0;
            wtag0_q  <= '0;
            wtag1_q  <= '0;
            wdata0_q <= '0;
            wdata1_q <= '0;
            rob0_q   <= '0;
            rob1_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen0_q   <= found0;
            wen1_q   <= found1;
            if (found0) begin
                wtag0_q  <= tag0_d;
                wdata0_q <= data0_d;
                rob0_q   <= rob0_d;
            end
            if (found1) begin
                wtag1_q  <= tag1_d;
                wdata1_q <= data1_d;
                rob1_q   <= rob1_d;
            end
        end
    end

    // Rename hands out unique tags, so paired grants must differ.
    always @(posedge clk) begin
        if (!reset && found1) begin
            assert (tag0_d != tag1_d)
            else $error("wb_arbiter: duplicate tag %0d on both ports", tag0_d);
        end
        if (!reset && found0) begin
            assert (int'(tag0_d) < PREGS)
            else $error("wb_arbiter: tag %0d out of range", tag0_d);
        end
    end

    assign wen0     = wen0_q;
    assign wen1     = wen1_q;
    assign wtag0    = wtag0_q;
    assign wtag1    = wtag1_q;
    assign wdata0   = wdata0_q;
    assign wdata1   = wdata1_q;
    assign cdb_rob0 = rob0_q;
    assign cdb_rob1 = rob1_q;

endmodule
